mem_write_checker: RTL and testbench
====================================

Name: mem_write_checker

Overview:
- Synthesizable end-of-test monitor for the CPU top-level bench.
- Watches the data-memory write bus (memwrite, dataadr, writedata) and compares each write against an ordered table of expected writes.
- Reports pass or fail with a cause code, and enforces a cycle timeout.
- Generalises the single-address success/fail check to a parametrised sequence: DEPTH entries, any bus width, one ignored scratch address.

Parameters:
AW, 32, address width
DW, 32, data width
DEPTH, 8, number of expected-write table entries
CW, 16, cycle counter width
TIMEOUT, 1000, RUN cycles before timeout failure (must be < 2**CW)
IGNORE_USE, 1, 1 = writes to IGNORE_ADDR are skipped
IGNORE_ADDR, 80, scratch address excluded from checking

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
exp_valid  in  1  expected-entry load strobe
exp_addr  in  AW  expected address
exp_data  in  DW  expected data
exp_mask  in  DW  per-bit compare mask (used only with CHK_DATA_MASK_EN)
exp_ready  out  1  table can accept an entry
start  in  1  end loading, begin checking
memwrite  in  1  CPU data-memory write enable
dataadr  in  AW  CPU write address
writedata  in  DW  CPU write data
done  out  1  verdict reached
pass  out  1  verdict is pass
fail_code  out  2  0 none, 1 address mismatch, 2 data mismatch, 3 timeout
fail_addr  out  AW  address of the failing write
fail_data  out  DW  data of the failing write
match_cnt  out  $clog2(DEPTH+1)  writes matched so far
cycle_cnt  out  CW  cycles spent in RUN

Behaviour:
- Reset value of every output and pointer is 0, except exp_ready, which is 1. State after reset is LOAD. Table contents are not cleared. A reset in any state, including mid-RUN, returns to LOAD and clears the pointers and counters.
- States: LOAD, RUN, PASS, FAIL.
- LOAD:
  - exp_ready = (wr_ptr < DEPTH).
  - exp_valid && exp_ready stores the entry at wr_ptr and increments wr_ptr. A load with exp_ready low is dropped.
  - start moves to RUN on the next edge. If wr_ptr == 0 (after counting any same-cycle load), it moves to PASS instead.
  - exp_valid and start in the same cycle: the entry is accepted and is included in the check.
  - memwrite is ignored.
- RUN:
  - exp_ready = 0. cycle_cnt increments every cycle.
  - A memwrite with IGNORE_USE=1 and dataadr == IGNORE_ADDR is skipped.
  - Any other memwrite is compared against entry rd_ptr:
    - Address and data equal: rd_ptr++ and match_cnt++. If this was the last entry (rd_ptr == wr_ptr-1), go to PASS.
    - Address differs: FAIL, fail_code = 1.
    - Address equal, data differs: FAIL, fail_code = 2.
    - On FAIL, dataadr and writedata are captured into fail_addr and fail_data.
  - When cycle_cnt reaches TIMEOUT-1 with no verdict: FAIL, fail_code = 3, fail_addr and fail_data remain 0.
  - Priority: a write verdict (pass or fail) beats timeout in the same cycle.
- PASS and FAIL are terminal until reset:
  - done = 1; pass = 1 only in PASS.
  - All inputs except reset are ignored. cycle_cnt and match_cnt freeze.
- Latency: a write sampled at edge N is reflected in done, pass, fail_* and match_cnt after edge N. Outputs are all registered.
- start and exp_valid outside LOAD have no effect.

Optional Feature:
- CHK_DATA_MASK_EN defined:
  - exp_mask is stored per entry.
  - The data comparison is (writedata & mask) == (exp_data & mask); fail_code 2 uses the masked compare.
  - A mask of 0 matches any data.
- Undefined:
  - exp_mask is ignored and no mask storage is built.
  - The full-width equality compare is used.

Decomposition:
- Shared package mem_chk_pkg holds:
  - the state enum (LOAD, RUN, PASS, FAIL);
  - fail-code constants FC_NONE=0, FC_ADDR=1, FC_DATA=2, FC_TIMEOUT=3;
  - an entry struct {addr, data, mask}.
- One sub-module, mem_chk_table: DEPTH-entry register file with write port (wr_ptr) and read port (rd_ptr), mask field conditional on the macro.
- Top level holds the FSM, counters and compare logic.

Test Plan:
- Scratch write ignored, then match: load (84, 7); start; write (80, 3) then (84, 7) -> done=1, pass=1, match_cnt=1, fail_code=0.
- Address mismatch: load (84, 7); start; write (88, 7) -> pass=0, fail_code=1, fail_addr=88, fail_data=7.
- Data mismatch: load (84, 7); start; write (84, 6) -> fail_code=2, fail_data=6, match_cnt=0.
- Timeout: TIMEOUT=20; load one entry; start; no writes -> done at cycle_cnt=19, fail_code=3. Separately, a matching final write in that same cycle -> pass=1.
- Table full and empty start: 9 loads with DEPTH=8 -> exp_ready low after the 8th and the 9th is dropped. Separately, reset, then start with no loads -> pass=1 on the next cycle. Reset mid-RUN -> state LOAD, all counters 0.
- Data mask: with CHK_DATA_MASK_EN, load (84, 0x07, mask 0xFF); write (84, 0xAB07) -> pass=1. Without the macro, the same stimulus -> fail_code=2.

Source files
------------

// File: rtl/mem_chk_pkg.sv
// Shared definitions for the memory write checker.
// Contents:
//   state_t      checker FSM states (LOAD, RUN, PASS, FAIL)
//   fc_t + FC_*  verdict cause codes reported on fail_code
//   entry_t      one expected-write record {addr, data, mask} at the default
//                32-bit bus widths; the table stores the same three fields
//                at whatever widths the instance is configured for.
package mem_chk_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    PASS = 2'd2,
    FAIL = 2'd3
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_ADDR    = 2'd1;
  localparam logic [1:0] FC_DATA    = 2'd2;
  localparam logic [1:0] FC_TIMEOUT = 2'd3;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [31:0] mask;
  } entry_t;

endpackage

// File: rtl/mem_chk_table.sv
// Expected-write table: DEPTH-entry register file, one write port and one
// asynchronous read port. Contents are never reset; only the pointers that
// index it are.
// Optional macro: CHK_DATA_MASK_EN adds a per-entry compare mask field.
// Ports:
//   clk               clock
//   wr_en             store wr_addr/wr_data(/wr_mask) at wr_idx
//   wr_idx, rd_idx    write / read entry index
//   wr_addr, wr_data  entry fields to store
//   wr_mask           entry mask (only with CHK_DATA_MASK_EN)
//   rd_addr, rd_data  fields of entry rd_idx
//   rd_mask           mask of entry rd_idx (only with CHK_DATA_MASK_EN)
module mem_chk_table
  import mem_chk_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
`ifdef CHK_DATA_MASK_EN
  input  logic [DW-1:0] wr_mask,
  output logic [DW-1:0] rd_mask,
`endif
  input  logic [IW-1:0] rd_idx,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [AW-1:0] mem_addr [DEPTH];
  logic [DW-1:0] mem_data [DEPTH];
`ifdef CHK_DATA_MASK_EN
  logic [DW-1:0] mem_mask [DEPTH];
`endif

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_addr[wr_idx] <= wr_addr;
      mem_data[wr_idx] <= wr_data;
`ifdef CHK_DATA_MASK_EN
      mem_mask[wr_idx] <= wr_mask;
`endif
    end
  end

  assign rd_addr = mem_addr[rd_idx];
  assign rd_data = mem_data[rd_idx];
`ifdef CHK_DATA_MASK_EN
  assign rd_mask = mem_mask[rd_idx];
`endif

endmodule

// File: rtl/mem_write_checker.sv
// End-of-test monitor: compares CPU data-memory writes against an ordered
// table of expected writes and reports a pass/fail verdict with a cause code.
// Optional macro: CHK_DATA_MASK_EN enables per-entry masked data compare.
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   exp_valid/addr/data/mask      expected-entry load (mask used with macro)
//   exp_ready                     table accepts an entry (LOAD, not full)
//   start                         end loading, begin checking
//   memwrite, dataadr, writedata  CPU write bus being monitored
//   done, pass                    verdict reached / verdict is pass
//   fail_code                     0 none, 1 addr, 2 data, 3 timeout
//   fail_addr, fail_data          the offending write
//   match_cnt, cycle_cnt          writes matched / cycles spent in RUN
module mem_write_checker
  import mem_chk_pkg::*;
#(
  parameter int            AW          = 32,
  parameter int            DW          = 32,
  parameter int            DEPTH       = 8,
  parameter int            CW          = 16,
  parameter int            TIMEOUT     = 1000,
  parameter bit            IGNORE_USE  = 1'b1,
  parameter logic [AW-1:0] IGNORE_ADDR = AW'(80)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       exp_valid,
  input  logic [AW-1:0]              exp_addr,
  input  logic [DW-1:0]              exp_data,
  input  logic [DW-1:0]              exp_mask,
  output logic                       exp_ready,
  input  logic                       start,
  input  logic                       memwrite,
  input  logic [AW-1:0]              dataadr,
  input  logic [DW-1:0]              writedata,
  output logic                       done,
  output logic                       pass,
  output logic [1:0]                 fail_code,
  output logic [AW-1:0]              fail_addr,
  output logic [DW-1:0]              fail_data,
  output logic [$clog2(DEPTH+1)-1:0] match_cnt,
  output logic [CW-1:0]              cycle_cnt
);

  localparam int PW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_nxt;
  logic [CW-1:0] cnt_nxt;
  logic [AW-1:0] ent_addr;
  logic [DW-1:0] ent_data;
  logic [DW-1:0] ent_mask;
  logic          load_acc;
  logic          chk_write;
  logic          addr_ok;
  logic          data_ok;
  logic          last_ent;

`ifdef CHK_DATA_MASK_EN
  function automatic logic data_eq(input logic [DW-1:0] wd,
                                   input logic [DW-1:0] ed,
                                   input logic [DW-1:0] m);
    return (wd & m) == (ed & m);
  endfunction
`else
  function automatic logic data_eq(input logic [DW-1:0] wd,
                                   input logic [DW-1:0] ed,
                                   input logic [DW-1:0] m);
    logic unused_m;
    unused_m = ^m;
    return wd == ed;
  endfunction

  // No mask storage in this build; the mask port is accepted and dropped.
  logic unused_exp_mask;
  assign unused_exp_mask = ^exp_mask;
  assign ent_mask = '1;
`endif

  mem_chk_table #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .IW(IW)
  ) u_table (
    .clk    (clk),
    .wr_en  (load_acc),
    .wr_idx (wr_ptr[IW-1:0]),
    .wr_addr(exp_addr),
    .wr_data(exp_data),
`ifdef CHK_DATA_MASK_EN
    .wr_mask(exp_mask),
    .rd_mask(ent_mask),
`endif
    .rd_idx (rd_ptr[IW-1:0]),
    .rd_addr(ent_addr),
    .rd_data(ent_data)
  );

  assign load_acc   = (state == LOAD) && exp_valid && exp_ready;
  assign wr_ptr_nxt = load_acc ? wr_ptr + PW'(1) : wr_ptr;
  assign cnt_nxt    = cycle_cnt + CW'(1);

  // Writes to the scratch address never take part in the check.
  assign chk_write = memwrite && !(IGNORE_USE && (dataadr == IGNORE_ADDR));
  assign addr_ok   = (dataadr == ent_addr);
  assign data_ok   = data_eq(writedata, ent_data, ent_mask);
  assign last_ent  = (rd_ptr == wr_ptr - PW'(1));

  assign match_cnt = rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cycle_cnt <= '0;
      exp_ready <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail_code <= FC_NONE;
      fail_addr <= '0;
      fail_data <= '0;
    end else begin
      case (state)
        LOAD: begin
          wr_ptr    <= wr_ptr_nxt;
          exp_ready <= (wr_ptr_nxt < PW'(DEPTH));
          if (start) begin
            exp_ready <= 1'b0;
            // An empty table (counting a same-cycle load) passes at once.
            if (wr_ptr_nxt == '0) begin
              state <= PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          cycle_cnt <= cnt_nxt;
          if (chk_write && !addr_ok) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_ADDR;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else if (chk_write && !data_ok) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_DATA;
            fail_addr <= dataadr;
            fail_data <= writedata;
          end else if (chk_write) begin
            rd_ptr <= rd_ptr + PW'(1);
            if (last_ent) begin
              state <= PASS;
              done  <= 1'b1;
              pass  <= 1'b1;
            end
          end
          // Timeout only fires when no write verdict was reached this cycle.
          if (!(chk_write && (!addr_ok || !data_ok || last_ent)) &&
              (cnt_nxt == CW'(TIMEOUT - 1))) begin
            state     <= FAIL;
            done      <= 1'b1;
            fail_code <= FC_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_write_checker.sv
module tb_mem_write_checker;
  import mem_chk_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 8;
  localparam int CW = 16;
  localparam int MW = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          exp_valid;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;
  logic [DW-1:0] exp_mask;
  logic          exp_ready;
  logic          start;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          done;
  logic          pass;
  logic [1:0]    fail_code;
  logic [AW-1:0] fail_addr;
  logic [DW-1:0] fail_data;
  logic [MW-1:0] match_cnt;
  logic [CW-1:0] cycle_cnt;

  int compared = 0;
  int mismatched = 0;

  mem_write_checker #(
    .AW(AW), .DW(DW), .DEPTH(DEPTH), .CW(CW), .TIMEOUT(20),
    .IGNORE_USE(1'b1), .IGNORE_ADDR(32'd80)
  ) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_addr(exp_addr), .exp_data(exp_data),
    .exp_mask(exp_mask), .exp_ready(exp_ready), .start(start),
    .memwrite(memwrite), .dataadr(dataadr), .writedata(writedata),
    .done(done), .pass(pass), .fail_code(fail_code),
    .fail_addr(fail_addr), .fail_data(fail_data),
    .match_cnt(match_cnt), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; exp_valid = 1'b0; start = 1'b0; memwrite = 1'b0;
    exp_addr = '0; exp_data = '0; exp_mask = '0; dataadr = '0; writedata = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW-1:0] m);
    exp_valid = 1'b1; exp_addr = a; exp_data = d; exp_mask = m;
    tick();
    exp_valid = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memwrite = 1'b1; dataadr = a; writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    check("rst_exp_ready", exp_ready, 1);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_fail_code", fail_code, 0);
    check("rst_match_cnt", match_cnt, 0);
    check("rst_cycle_cnt", cycle_cnt, 0);
    check("rst_fail_addr", fail_addr, 0);

    // Scratch write ignored, then match
    load(32'd84, 32'd7, 32'hFFFF_FFFF);
    go();
    check("t1_ready_run", exp_ready, 0);
    wr(32'd80, 32'd3);
    check("t1_done_after_scratch", done, 0);
    check("t1_match_after_scratch", match_cnt, 0);
    wr(32'd84, 32'd7);
    check("t1_done", done, 1);
    check("t1_pass", pass, 1);
    check("t1_match_cnt", match_cnt, 1);
    check("t1_fail_code", fail_code, 0);
    wr(32'd88, 32'd1);
    check("t1_pass_frozen", pass, 1);
    check("t1_cycle_frozen", cycle_cnt, 2);
    check("t1_match_frozen", match_cnt, 1);

    // Address mismatch
    do_reset();
    load(32'd84, 32'd7, 32'hFFFF_FFFF);
    go();
    wr(32'd88, 32'd7);
    check("t2_done", done, 1);
    check("t2_pass", pass, 0);
    check("t2_fail_code", fail_code, 1);
    check("t2_fail_addr", fail_addr, 88);
    check("t2_fail_data", fail_data, 7);

    // Data mismatch
    do_reset();
    load(32'd84, 32'd7, 32'hFFFF_FFFF);
    go();
    wr(32'd84, 32'd6);
    check("t3_fail_code", fail_code, 2);
    check("t3_fail_addr", fail_addr, 84);
    check("t3_fail_data", fail_data, 6);
    check("t3_match_cnt", match_cnt, 0);

    // Timeout with no writes
    do_reset();
    load(32'd84, 32'd7, 32'hFFFF_FFFF);
    go();
    for (int i = 0; i < 18; i++) tick();
    check("t4_done_before", done, 0);
    check("t4_cycle_before", cycle_cnt, 18);
    tick();
    check("t4_done", done, 1);
    check("t4_pass", pass, 0);
    check("t4_fail_code", fail_code, 3);
    check("t4_cycle_cnt", cycle_cnt, 19);
    check("t4_fail_addr", fail_addr, 0);
    check("t4_fail_data", fail_data, 0);
    tick();
    check("t4_cycle_frozen", cycle_cnt, 19);

    // Final matching write in the timeout cycle wins
    do_reset();
    load(32'd84, 32'd7, 32'hFFFF_FFFF);
    go();
    for (int i = 0; i < 18; i++) tick();
    wr(32'd84, 32'd7);
    check("t5_pass", pass, 1);
    check("t5_fail_code", fail_code, 0);
    check("t5_cycle_cnt", cycle_cnt, 19);

    // Table full: ninth load dropped
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      check("t6_ready_before_load", exp_ready, 1);
      load(32'd100 + 32'(4 * i), 32'(i + 1), 32'hFFFF_FFFF);
    end
    check("t6_ready_full", exp_ready, 0);
    load(32'd200, 32'd99, 32'hFFFF_FFFF);
    go();
    for (int i = 0; i < DEPTH - 1; i++) wr(32'd100 + 32'(4 * i), 32'(i + 1));
    check("t6_done_before_last", done, 0);
    check("t6_match_before_last", match_cnt, 7);
    wr(32'd128, 32'd8);
    check("t6_pass", pass, 1);
    check("t6_match_cnt", match_cnt, 8);

    // Empty start passes immediately
    do_reset();
    go();
    check("t7_done", done, 1);
    check("t7_pass", pass, 1);
    check("t7_fail_code", fail_code, 0);

    // Load and start in the same cycle: entry is checked
    do_reset();
    exp_valid = 1'b1; exp_addr = 32'd84; exp_data = 32'd7; exp_mask = '1; start = 1'b1;
    tick();
    exp_valid = 1'b0; start = 1'b0;
    check("t8_not_done", done, 0);
    wr(32'd84, 32'd7);
    check("t8_pass", pass, 1);
    check("t8_match_cnt", match_cnt, 1);

    // Reset mid-RUN
    do_reset();
    load(32'd84, 32'd7, 32'hFFFF_FFFF);
    load(32'd88, 32'd9, 32'hFFFF_FFFF);
    go();
    wr(32'd84, 32'd7);
    check("t9_match_mid", match_cnt, 1);
    tick();
    do_reset();
    check("t9_exp_ready", exp_ready, 1);
    check("t9_done", done, 0);
    check("t9_match_cnt", match_cnt, 0);
    check("t9_cycle_cnt", cycle_cnt, 0);
    check("t9_fail_code", fail_code, 0);

    // Data mask
    do_reset();
    load(32'd84, 32'h07, 32'hFF);
    go();
    wr(32'd84, 32'hAB07);
    check("t10_done", done, 1);
`ifdef CHK_DATA_MASK_EN
    check("t10_pass", pass, 1);
    check("t10_fail_code", fail_code, 0);
`else
    check("t10_pass", pass, 0);
    check("t10_fail_code", fail_code, 2);
    check("t10_fail_data", fail_data, 32'hAB07);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
